// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Pure declarations; no logic, no latency.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_e;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_e;

   localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (I/D) and memory-side signals around the arbiter.
// slave = arbiter view; master = environment (core + memory macro) view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            i_req;
   logic [AW-1:0]   i_addr;
   logic            i_done;
   logic [DW-1:0]   i_rdata;

   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_wstrb;
   logic            d_done;
   logic [DW-1:0]   d_rdata;

   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic [DW-1:0]   mem_rdata;
   logic            mem_ready;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
      output i_done, i_rdata, d_done, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
      input  i_done, i_rdata, d_done, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between I and D; zero latency.
// Completing port is dropped from the candidate set; ARB_ROUND_ROBIN_EN selects alternation.
module arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic       i_req,
   input  logic       d_req,
   input  logic       i_cmpl,
   input  logic       d_cmpl,
`ifdef ARB_ROUND_ROBIN_EN
   input  port_e      last_grant,
`else
   input  logic [3:0] starve_cnt,
   output logic       contended,
`endif
   output logic       grant_vld,
   output port_e      grant
);

   logic i_cand;
   logic d_cand;

   always_comb begin
      i_cand    = i_req && !i_cmpl;
      d_cand    = d_req && !d_cmpl;
      grant_vld = i_cand || d_cand;
      grant     = PORT_I;
`ifdef ARB_ROUND_ROBIN_EN
      if (i_cand && d_cand)
         grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
      else if (d_cand)
         grant = PORT_D;
`else
      contended = i_cand && d_cand;
      // D normally wins contention; once I has lost STARVE_LIMIT times it is forced through.
      if (i_cand && d_cand)
         grant = (starve_cnt == 4'(STARVE_LIMIT)) ? PORT_I : PORT_D;
      else if (d_cand)
         grant = PORT_D;
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between I-fetch and D load/store; grant to mem_req in 1 cycle, no bubble.
// One transaction outstanding; requesters stall until their done pulse. ARB_ROUND_ROBIN_EN: alternate on contention.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   arb_state_e state;
   logic       i_cmpl;
   logic       d_cmpl;
   logic       decide;
   logic       grant_vld;
   port_e      grant;
`ifdef ARB_ROUND_ROBIN_EN
   port_e      last_grant;
`else
   logic [3:0] starve_cnt;
   logic       contended;
`endif

   // Reset abandons an in-flight access, so no done pulse may escape during it.
   assign i_cmpl = (state == BUSY_I) && bus.mem_ready && !rst;
   assign d_cmpl = (state == BUSY_D) && bus.mem_ready && !rst;
   assign decide = (state == IDLE) || i_cmpl || d_cmpl;

   assign bus.i_done  = i_cmpl;
   assign bus.d_done  = d_cmpl;
   assign bus.i_rdata = i_cmpl ? bus.mem_rdata : '0;
   assign bus.d_rdata = d_cmpl ? bus.mem_rdata : '0;

   arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .i_req      (bus.i_req),
      .d_req      (bus.d_req),
      .i_cmpl     (i_cmpl),
      .d_cmpl     (d_cmpl),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant),
`else
      .starve_cnt (starve_cnt),
      .contended  (contended),
`endif
      .grant_vld  (grant_vld),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant    <= PORT_I;
`else
         starve_cnt    <= '0;
`endif
      end else if (decide) begin
         if (grant_vld && grant == PORT_D) begin
            state         <= BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_wstrb <= bus.d_wstrb;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= PORT_D;
`else
            if (contended)
               starve_cnt <= starve_cnt + 4'd1;
`endif
         end else if (grant_vld) begin
            state         <= BUSY_I;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.i_addr;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= PORT_I;
`else
            starve_cnt    <= '0;
`endif
         end else begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   mem_lat;
   int   wait_cnt;
   logic [31:0] rdata_val;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(
      .STARVE_LIMIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory completes a request mem_lat cycles after it is presented.
   always @(posedge clk) begin
      if (rst || !bus.mem_req || bus.mem_ready)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end
   assign bus.mem_ready = bus.mem_req && (wait_cnt == mem_lat);
   assign bus.mem_rdata = rdata_val;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.d_wstrb = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] exp_seq;
      logic       got_d;
      checks    = 0;
      failures  = 0;
      mem_lat   = 1;
      rdata_val = 32'h0;
      clear_inputs();

      // Reset held with both ports requesting
      rst         = 1'b1;
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h100;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h300;
      tick();
      tick();
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_i_done", bus.i_done, 0);
      check("rst_d_done", bus.d_done, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      rst = 1'b0;
      tick();
      check("rel_mem_req", bus.mem_req, 1);
      check("rel_mem_we", bus.mem_we, 0);
      check("rel_mem_addr", bus.mem_addr, 32'h300);

      // Single I read, memory answers 2 cycles after mem_req
      do_reset();
      mem_lat     = 2;
      rdata_val   = 32'hDEADBEEF;
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h100;
      tick();
      check("ird_mem_req", bus.mem_req, 1);
      check("ird_mem_addr", bus.mem_addr, 32'h100);
      check("ird_mem_we", bus.mem_we, 0);
      tick();
      check("ird_early_done", bus.i_done, 0);
      check("ird_rdata_idle", bus.i_rdata, 0);
      tick();
      check("ird_done", bus.i_done, 1);
      check("ird_rdata", bus.i_rdata, 32'hDEADBEEF);
      check("ird_no_d_done", bus.d_done, 0);
      bus.i_req = 1'b0;
      tick();
      check("ird_done_once", bus.i_done, 0);
      check("ird_rdata_zero", bus.i_rdata, 0);
      check("ird_mem_req_off", bus.mem_req, 0);

      // D write with I pending: D first, then I with no bubble
      do_reset();
      mem_lat     = 1;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'h12345678;
      bus.d_wstrb = 4'b0011;
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h104;
      tick();
      check("dwr_mem_addr", bus.mem_addr, 32'h200);
      check("dwr_mem_we", bus.mem_we, 1);
      check("dwr_mem_wstrb", bus.mem_wstrb, 4'b0011);
      check("dwr_mem_wdata", bus.mem_wdata, 32'h12345678);
      tick();
      check("dwr_d_done", bus.d_done, 1);
      check("dwr_i_done_excl", bus.i_done, 0);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      check("b2b_mem_req", bus.mem_req, 1);
      check("b2b_mem_addr", bus.mem_addr, 32'h104);
      check("b2b_mem_we", bus.mem_we, 0);
      check("b2b_mem_wstrb", bus.mem_wstrb, 0);
      check("b2b_d_done_off", bus.d_done, 0);
      tick();
      check("b2b_i_done", bus.i_done, 1);
      bus.i_req = 1'b0;
      tick();
      check("b2b_idle", bus.mem_req, 0);

      // Contention rounds: both raise together in IDLE, loser withdraws
      do_reset();
      mem_lat = 1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = 10'h155;
`else
      exp_seq = 10'h1EF;
`endif
      for (int r = 0; r < 10; r++) begin
         bus.d_req  = 1'b1;
         bus.d_we   = 1'b0;
         bus.d_addr = 32'h400;
         bus.i_req  = 1'b1;
         bus.i_addr = 32'h500;
         tick();
         got_d = (bus.mem_addr == 32'h400);
         check($sformatf("grant_%0d", r), got_d, exp_seq[r]);
         if (got_d) bus.i_req = 1'b0;
         else       bus.d_req = 1'b0;
         tick();
         check($sformatf("done_%0d", r), got_d ? bus.d_done : bus.i_done, 1);
         bus.i_req = 1'b0;
         bus.d_req = 1'b0;
         tick();
         check($sformatf("idle_%0d", r), bus.mem_req, 0);
      end

      // Reset during the completion cycle of a D read
      do_reset();
      mem_lat    = 1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h600;
      tick();
      check("rmid_mem_req", bus.mem_req, 1);
      tick();
      rst       = 1'b1;
      bus.d_req = 1'b0;
      #1;
      check("rmid_no_d_done", bus.d_done, 0);
      tick();
      check("rmid_mem_req_off", bus.mem_req, 0);
      check("rmid_d_done_off", bus.d_done, 0);
      rst        = 1'b0;
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h700;
      tick();
      check("rmid_fresh_req", bus.mem_req, 1);
      check("rmid_fresh_addr", bus.mem_addr, 32'h700);
      tick();
      check("rmid_fresh_done", bus.i_done, 1);
      bus.i_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
